// File: rtl/operand_fetch_if.sv
// Decode-to-execute handshake bundle for operand_fetch.
// The slave modport is the fetch stage; master is the surrounding pipeline.
interface operand_fetch_if #(
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 32,
  parameter int unsigned PAYLOAD_W = 16
);
  logic                 dec_valid;
  logic                 dec_ready;
  logic [AW-1:0]        dec_ra1;
  logic [AW-1:0]        dec_ra2;
  logic [AW-1:0]        dec_wa;
  logic                 dec_we;
  logic [PAYLOAD_W-1:0] dec_payload;

  logic                 ex_valid;
  logic                 ex_ready;
  logic [DW-1:0]        ex_op1;
  logic [DW-1:0]        ex_op2;
  logic [AW-1:0]        ex_wa;
  logic                 ex_we;
  logic [PAYLOAD_W-1:0] ex_payload;

  modport master (
    output dec_valid, dec_ra1, dec_ra2, dec_wa, dec_we, dec_payload, ex_ready,
    input  dec_ready, ex_valid, ex_op1, ex_op2, ex_wa, ex_we, ex_payload
  );

  modport slave (
    input  dec_valid, dec_ra1, dec_ra2, dec_wa, dec_we, dec_payload, ex_ready,
    output dec_ready, ex_valid, ex_op1, ex_op2, ex_wa, ex_we, ex_payload
  );
endinterface

// File: rtl/operand_fetch.sv
// Issue stage: scoreboarded hazard wait, regfile read, operand hand-off to execute.
// Define OPFETCH_BYPASS_EN to forward writeback data to pending sources while in CHK.
module operand_fetch #(
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 32,
  parameter int unsigned PAYLOAD_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  bus,
  output logic [AW-1:0]   rf_ra1,
  output logic [AW-1:0]   rf_ra2,
  input  logic [DW-1:0]   rf_rd1,
  input  logic [DW-1:0]   rf_rd2,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [DW-1:0]   wb_wd,
  output logic [15:0]     stall_cnt
);

  localparam int unsigned NumRegs = 2 ** AW;

  typedef enum logic [2:0] {StIdle, StChk, StRd, StData, StOut} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic                 we_q, we_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [NumRegs-1:0]   pend_q, pend_d;
  logic [15:0]          stall_q, stall_d;
  logic                 ex_valid_q, ex_valid_d;
  logic [DW-1:0]        ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
  logic [AW-1:0]        ex_wa_q, ex_wa_d;
  logic                 ex_we_q, ex_we_d;
  logic [PAYLOAD_W-1:0] ex_payload_q, ex_payload_d;

  logic src1_haz, src2_haz, dst_haz, hazard;
  logic [DW-1:0] op1_src, op2_src;

`ifdef OPFETCH_BYPASS_EN
  logic [DW-1:0] byp1_q, byp1_d, byp2_q, byp2_d;
  logic          byp1_v_q, byp1_v_d, byp2_v_q, byp2_v_d;
  logic          wb_hit1, wb_hit2;

  // A pending source whose writeback lands this cycle is satisfied by forwarding.
  assign wb_hit1  = wb_we && (wb_wa == ra1_q) && pend_q[ra1_q];
  assign wb_hit2  = wb_we && (wb_wa == ra2_q) && pend_q[ra2_q];
  assign src1_haz = pend_q[ra1_q] && !wb_hit1;
  assign src2_haz = pend_q[ra2_q] && !wb_hit2;
  assign op1_src  = byp1_v_q ? byp1_q : rf_rd1;
  assign op2_src  = byp2_v_q ? byp2_q : rf_rd2;
`else
  logic unused_wb_wd;

  assign unused_wb_wd = ^wb_wd;
  assign src1_haz     = pend_q[ra1_q];
  assign src2_haz     = pend_q[ra2_q];
  assign op1_src      = rf_rd1;
  assign op2_src      = rf_rd2;
`endif

  assign dst_haz = we_q && pend_q[wa_q];
  assign hazard  = src1_haz || src2_haz || dst_haz;

  always_comb begin
    state_d      = state_q;
    ra1_d        = ra1_q;
    ra2_d        = ra2_q;
    wa_d         = wa_q;
    we_d         = we_q;
    payload_d    = payload_q;
    pend_d       = pend_q;
    stall_d      = stall_q;
    ex_valid_d   = ex_valid_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_wa_d      = ex_wa_q;
    ex_we_d      = ex_we_q;
    ex_payload_d = ex_payload_q;
`ifdef OPFETCH_BYPASS_EN
    byp1_d       = byp1_q;
    byp2_d       = byp2_q;
    byp1_v_d     = byp1_v_q;
    byp2_v_d     = byp2_v_q;
`endif

    if (wb_we) pend_d[wb_wa] = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.dec_valid) begin
          ra1_d     = bus.dec_ra1;
          ra2_d     = bus.dec_ra2;
          wa_d      = bus.dec_wa;
          we_d      = bus.dec_we;
          payload_d = bus.dec_payload;
          state_d   = StChk;
        end
      end
      StChk: begin
`ifdef OPFETCH_BYPASS_EN
        if (wb_hit1) begin
          byp1_d   = wb_wd;
          byp1_v_d = 1'b1;
        end
        if (wb_hit2) begin
          byp2_d   = wb_wd;
          byp2_v_d = 1'b1;
        end
`endif
        if (hazard) begin
          if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end else begin
          state_d = StRd;
        end
      end
      StRd: state_d = StData;
      StData: begin
        ex_op1_d     = op1_src;
        ex_op2_d     = op2_src;
        ex_wa_d      = wa_q;
        ex_we_d      = we_q;
        ex_payload_d = payload_q;
        ex_valid_d   = 1'b1;
        state_d      = StOut;
      end
      StOut: begin
        if (bus.ex_ready) begin
          ex_valid_d = 1'b0;
          // Applied after the writeback clear so a same-index set wins.
          if (ex_we_q) pend_d[ex_wa_q] = 1'b1;
`ifdef OPFETCH_BYPASS_EN
          byp1_v_d = 1'b0;
          byp2_v_d = 1'b0;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ra1_q        <= '0;
      ra2_q        <= '0;
      wa_q         <= '0;
      we_q         <= 1'b0;
      payload_q    <= '0;
      pend_q       <= '0;
      stall_q      <= '0;
      ex_valid_q   <= 1'b0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_wa_q      <= '0;
      ex_we_q      <= 1'b0;
      ex_payload_q <= '0;
`ifdef OPFETCH_BYPASS_EN
      byp1_q       <= '0;
      byp2_q       <= '0;
      byp1_v_q     <= 1'b0;
      byp2_v_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ra1_q        <= ra1_d;
      ra2_q        <= ra2_d;
      wa_q         <= wa_d;
      we_q         <= we_d;
      payload_q    <= payload_d;
      pend_q       <= pend_d;
      stall_q      <= stall_d;
      ex_valid_q   <= ex_valid_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_wa_q      <= ex_wa_d;
      ex_we_q      <= ex_we_d;
      ex_payload_q <= ex_payload_d;
`ifdef OPFETCH_BYPASS_EN
      byp1_q       <= byp1_d;
      byp2_q       <= byp2_d;
      byp1_v_q     <= byp1_v_d;
      byp2_v_q     <= byp2_v_d;
`endif
    end
  end

  assign bus.dec_ready  = (state_q == StIdle);
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_op1     = ex_op1_q;
  assign bus.ex_op2     = ex_op2_q;
  assign bus.ex_wa      = ex_wa_q;
  assign bus.ex_we      = ex_we_q;
  assign bus.ex_payload = ex_payload_q;
  assign rf_ra1         = ra1_q;
  assign rf_ra2         = ra2_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: regfile model, scoreboard of expected ex_* beats,
// table-driven issue vectors plus hazard, backpressure, saturation and reset sequences.
module tb_operand_fetch;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;
`ifdef OPFETCH_BYPASS_EN
  localparam int RawStall = 4;
`else
  localparam int RawStall = 5;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rf_ra1, rf_ra2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  operand_fetch_if #(.AW(AW), .DW(DW), .PAYLOAD_W(PW)) bus ();

  operand_fetch #(.AW(AW), .DW(DW), .PAYLOAD_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      3:       return 32'h11;
      4:       return 32'h22;
      default: return 32'hC0DE_0000 + 32'(i);
    endcase
  endfunction

  // Registered-read regfile, written by the same writeback strobe the DUT sees.
  logic [DW-1:0] regs [2**AW];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) regs[i] <= init_val(i);
      rf_rd1 <= '0;
      rf_rd2 <= '0;
    end else begin
      rf_rd1 <= regs[rf_ra1];
      rf_rd2 <= regs[rf_ra2];
      if (wb_we) regs[wb_wa] <= wb_wd;
    end
  end

  typedef struct {
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic          we;
    logic [PW-1:0] payload;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } vec_t;

  typedef struct {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [AW-1:0] wa;
    logic          we;
    logic [PW-1:0] payload;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v, input bit push);
    chk("dec_ready before issue", 32'(bus.dec_ready), 32'd1);
    bus.dec_ra1     = v.ra1;
    bus.dec_ra2     = v.ra2;
    bus.dec_wa      = v.wa;
    bus.dec_we      = v.we;
    bus.dec_payload = v.payload;
    bus.dec_valid   = 1'b1;
    if (push) sb.push_back('{op1: v.op1, op2: v.op2, wa: v.wa, we: v.we, payload: v.payload});
    tick();
    bus.dec_valid = 1'b0;
  endtask

  task automatic wait_ex(input int limit, output int edges);
    edges = 0;
    while (!bus.ex_valid && edges < limit) begin
      tick();
      edges++;
    end
    chk("ex_valid within bound", 32'(bus.ex_valid), 32'd1);
  endtask

  task automatic pulse_wb(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    wb_we = 1'b1;
    wb_wa = wa;
    wb_wd = wd;
    tick();
    wb_we = 1'b0;
  endtask

  // Scoreboard: one beat consumed per cycle with ex_valid & ex_ready.
  always @(negedge clk) begin
    if (!rst && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected handshake", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ex_op1", bus.ex_op1, e.op1);
        chk("ex_op2", bus.ex_op2, e.op2);
        chk("ex_wa", 32'(bus.ex_wa), 32'(e.wa));
        chk("ex_we", 32'(bus.ex_we), 32'(e.we));
        chk("ex_payload", 32'(bus.ex_payload), 32'(e.payload));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    vec_t        v;
    int          e;
    logic [15:0] s0;

    vecs[0] = '{ra1: 3,  ra2: 4,  wa: 5, we: 1, payload: 16'h1234, op1: 32'h11,        op2: 32'h22};
    vecs[1] = '{ra1: 7,  ra2: 7,  wa: 8, we: 0, payload: 16'hBEEF, op1: 32'hC0DE0007, op2: 32'hC0DE0007};
    vecs[2] = '{ra1: 0,  ra2: 63, wa: 9, we: 1, payload: 16'hFFFF, op1: 32'hC0DE0000, op2: 32'hC0DE003F};
    vecs[3] = '{ra1: 10, ra2: 11, wa: 9, we: 0, payload: 16'h0000, op1: 32'hC0DE000A, op2: 32'hC0DE000B};
    vecs[4] = '{ra1: 4,  ra2: 3,  wa: 4, we: 1, payload: 16'h00A5, op1: 32'h22,        op2: 32'h11};

    rst           = 1'b1;
    wb_we         = 1'b0;
    wb_wa         = '0;
    wb_wd         = '0;
    bus.dec_valid = 1'b0;
    bus.dec_ra1   = '0;
    bus.dec_ra2   = '0;
    bus.dec_wa    = '0;
    bus.dec_we    = 1'b0;
    bus.dec_payload = '0;
    bus.ex_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset dec_ready", 32'(bus.dec_ready), 32'd1);
    chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset rf_ra1", 32'(rf_ra1), 32'd0);
    chk("reset rf_ra2", 32'(rf_ra2), 32'd0);
    chk("reset ex_op1", bus.ex_op1, 32'd0);
    chk("reset ex_payload", 32'(bus.ex_payload), 32'd0);

    // Independent instructions: 3-edge latency, no stalls.
    for (int k = 0; k < 5; k++) begin
      s0 = stall_cnt;
      issue(vecs[k], 1'b1);
      wait_ex(20, e);
      chk($sformatf("vec%0d latency", k), 32'(e), 32'd3);
      chk($sformatf("vec%0d stall delta", k), 32'(16'(stall_cnt - s0)), 32'd0);
      chk($sformatf("vec%0d rf_ra1", k), 32'(rf_ra1), 32'(vecs[k].ra1));
      tick();
      chk($sformatf("vec%0d ex_valid after handshake", k), 32'(bus.ex_valid), 32'd0);
    end

    // Backpressure: outputs hold for 5 cycles, single handshake on release.
    bus.ex_ready = 1'b0;
    v = '{ra1: 20, ra2: 21, wa: 22, we: 0, payload: 16'h5A5A,
          op1: 32'hC0DE0014, op2: 32'hC0DE0015};
    issue(v, 1'b1);
    wait_ex(20, e);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp ex_valid", 32'(bus.ex_valid), 32'd1);
      chk("bp ex_op1", bus.ex_op1, v.op1);
      chk("bp ex_op2", bus.ex_op2, v.op2);
      chk("bp ex_payload", 32'(bus.ex_payload), 32'(v.payload));
      chk("bp dec_ready", 32'(bus.dec_ready), 32'd0);
    end
    chk("bp beat still queued", 32'(sb.size()), 32'd1);
    bus.ex_ready = 1'b1;
    tick();
    chk("bp ex_valid after release", 32'(bus.ex_valid), 32'd0);
    chk("bp beat consumed once", 32'(sb.size()), 32'd0);

    // RAW on r5 (pending from vecs[0]); writeback lands in the 5th CHK cycle.
    s0 = stall_cnt;
    v  = '{ra1: 5, ra2: 3, wa: 13, we: 0, payload: 16'h0A0A, op1: 32'h0000ABCD, op2: 32'h11};
    issue(v, 1'b1);
    repeat (4) tick();
    chk("raw held before wb", 32'(bus.ex_valid), 32'd0);
    pulse_wb(5, 32'h0000ABCD);
    wait_ex(20, e);
    chk("raw latency", 32'(e + 5), 32'(3 + RawStall));
    chk("raw stall delta", 32'(16'(stall_cnt - s0)), 32'(RawStall));
    tick();

    // WAW on r9: dest check is never bypassed.
    s0 = stall_cnt;
    v  = '{ra1: 1, ra2: 2, wa: 9, we: 1, payload: 16'h0909, op1: 32'hC0DE0001, op2: 32'hC0DE0002};
    issue(v, 1'b1);
    repeat (6) tick();
    chk("waw held in chk", 32'(bus.ex_valid), 32'd0);
    pulse_wb(9, 32'h99);
    wait_ex(20, e);
    chk("waw latency", 32'(e + 7), 32'd10);
    chk("waw stall delta", 32'(16'(stall_cnt - s0)), 32'd7);
    tick();

    // Saturation: very long RAW stall on r4.
    v = '{ra1: 4, ra2: 0, wa: 14, we: 0, payload: 16'hFFFF, op1: 32'h44, op2: 32'hC0DE0000};
    issue(v, 1'b1);
    repeat (70000) tick();
    chk("sat stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat held", 32'(bus.ex_valid), 32'd0);
    pulse_wb(4, 32'h44);
    wait_ex(20, e);
    tick();
    chk("sat stall_cnt after", 32'(stall_cnt), 32'h0000FFFF);

    // Reset while holding in OUT.
    bus.ex_ready = 1'b0;
    v = '{ra1: 3, ra2: 3, wa: 30, we: 1, payload: 16'h3333, op1: 32'h11, op2: 32'h11};
    issue(v, 1'b0);
    wait_ex(20, e);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("mid reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("mid reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("mid reset dec_ready", 32'(bus.dec_ready), 32'd1);
    chk("mid reset ex_op1", bus.ex_op1, 32'd0);
    chk("mid reset ex_wa", 32'(bus.ex_wa), 32'd0);
    bus.ex_ready = 1'b1;

    // Formerly pending registers must issue without stalls after reset.
    v = '{ra1: 5, ra2: 9, wa: 30, we: 1, payload: 16'h0001, op1: 32'hC0DE0005, op2: 32'hC0DE0009};
    issue(v, 1'b1);
    wait_ex(20, e);
    chk("post reset latency a", 32'(e), 32'd3);
    tick();
    v = '{ra1: 4, ra2: 14, wa: 0, we: 0, payload: 16'h0002, op1: 32'h22, op2: 32'hC0DE000E};
    issue(v, 1'b1);
    wait_ex(20, e);
    chk("post reset latency b", 32'(e), 32'd3);
    tick();
    chk("post reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
